// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC ownership, sync IMEM addressing, zero-bubble redirect, stall hold
// Splits the fetched word into decoder fields; all fields read as zero while no instruction is valid.
module fetch_stage #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [26:0]       jump_target,
  input  logic              branch_en,
  input  logic [16:0]       branch_offset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus1,
  output logic [4:0]        opcode,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        shamt,
  output logic [4:0]        alu_op,
  output logic [31:0]       imm_sext,
  output logic [26:0]       target,
  output logic [31:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_f_q, pc_f_d;
  logic [ADDR_W-1:0] pc_d_q, pc_d_d;
  logic              dvalid_q, dvalid_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic              redirect;
  logic [31:0]       br_sum;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_bits;

  // Branch sum is formed at full width so the wrap is correct for any ADDR_W.
  assign br_sum      = 32'(pc_d_q) + 32'd1 + {{15{branch_offset[16]}}, branch_offset};
  assign unused_bits = ^{jump_target[26:ADDR_W], br_sum[31:ADDR_W]};

  always_comb begin
    instr_valid   = dvalid_q & reset_n;
    redirect      = instr_valid & (jump_en | branch_en);
    tgt           = jump_en ? jump_target[ADDR_W-1:0] : br_sum[ADDR_W-1:0];

    // Stalling re-reads the held address so imem_q stays put next cycle.
    if (!reset_n)      imem_addr = pc_f_q;
    else if (stall)    imem_addr = pc_d_q;
    else if (redirect) imem_addr = tgt;
    else               imem_addr = pc_f_q;

    pc_f_d        = pc_f_q;
    pc_d_d        = pc_d_q;
    dvalid_d      = dvalid_q;
    fetch_count_d = fetch_count_q;
    if (!stall) begin
      pc_d_d   = imem_addr;
      pc_f_d   = imem_addr + ADDR_W'(1);
      dvalid_d = 1'b1;
      if (instr_valid) fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_f_q        <= RST_PC;
      pc_d_q        <= RST_PC;
      dvalid_q      <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_f_q        <= pc_f_d;
      pc_d_q        <= pc_d_d;
      dvalid_q      <= dvalid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_inc      = pc_d_q + ADDR_W'(1);
  assign instr       = instr_valid ? imem_q : 32'h0;
  assign pc_out      = 32'(pc_d_q);
  assign pc_plus1    = 32'(pc_inc);
  assign opcode      = instr[31:27];
  assign rd          = instr[26:22];
  assign rs          = instr[21:17];
  assign rt          = instr[16:12];
  assign shamt       = instr[11:7];
  assign alu_op      = instr[6:2];
  assign imm_sext    = {{15{instr[16]}}, instr[16:0]};
  assign target      = instr[26:0];
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table plus randomized run of fetch_stage against a sequence-level model
module tb_fetch_stage;
  localparam int AW   = 6;
  localparam int MASK = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset_n, stall, jump_en, branch_en;
  logic [26:0]   jump_target;
  logic [16:0]   branch_offset;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          instr_valid;
  logic [31:0]   instr, pc_out, pc_plus1, imm_sext, fetch_count;
  logic [4:0]    opcode, rd, rs, rt, shamt, alu_op;
  logic [26:0]   target;

  fetch_stage #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .jump_en(jump_en),
    .jump_target(jump_target), .branch_en(branch_en), .branch_offset(branch_offset),
    .imem_addr(imem_addr), .imem_q(imem_q), .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .shamt(shamt), .alu_op(alu_op), .imm_sext(imm_sext), .target(target),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:MASK];
  always @(posedge clock) imem_q <= mem[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Sequence-level model: which instruction is presented, whether it is real, how many handed off
  bit m_v   = 1'b0;
  int m_pc  = 0;
  int m_cnt = 0;

  typedef struct {
    bit rst_n; bit st; bit je; int jt; bit be; int off;
    bit ev; int epc; int ecnt; int eaddr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst_n, bit st, bit je, int jt, bit be, int off,
                              bit ev, int epc, int ecnt, int eaddr);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.je = je; v.jt = jt; v.be = be; v.off = off;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    tbl.push_back(v);
  endfunction

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic run_cycle(input bit rn, input bit st, input bit je, input int jt,
                           input bit be, input int off, input bit use_tbl, input bit ev,
                           input int epc, input int ecnt, input int eaddr, input bit do_chk);
    bit          v_e;
    int          pc_e, cnt_e, o, nxt, a_e;
    logic [31:0] ins_e;
    logic [26:0] jt27;
    logic [16:0] off17;
    v_e   = use_tbl ? ev   : m_v;
    pc_e  = use_tbl ? epc  : m_pc;
    cnt_e = use_tbl ? ecnt : m_cnt;
    if (do_chk) begin
      ins_e = v_e ? mem[pc_e] : 32'h0;
      chk("instr_valid", 128'(instr_valid), 128'(v_e));
      chk("instr", 128'(instr), 128'(ins_e));
      chk("pc_out", 128'(pc_out), 128'(pc_e));
      chk("pc_plus1", 128'(pc_plus1), 128'((pc_e + 1) & MASK));
      chk("fetch_count", 128'(fetch_count), 128'(cnt_e));
      chk("fields", 128'({opcode, rd, rs, rt, shamt, alu_op, imm_sext, target}),
          128'({ins_e[31:27], ins_e[26:22], ins_e[21:17], ins_e[16:12], ins_e[11:7],
                ins_e[6:2], {{15{ins_e[16]}}, ins_e[16:0]}, ins_e[26:0]}));
    end
    jt27  = 27'(jt);
    off17 = 17'(off);
    reset_n = rn; stall = st; jump_en = je; jump_target = jt27;
    branch_en = be; branch_offset = off17;
    #1;
    o = $signed(off17);
    if (!m_v)    nxt = m_pc;
    else if (je) nxt = int'(jt27) & MASK;
    else if (be) nxt = (m_pc + 1 + o) & MASK;
    else         nxt = (m_pc + 1) & MASK;
    a_e = st ? m_pc : nxt;
    if (do_chk && rn) chk("imem_addr", 128'(imem_addr), 128'(use_tbl ? eaddr : a_e));
    @(posedge clock);
    if (!rn) begin
      m_v = 1'b0; m_pc = 0; m_cnt = 0;
    end else if (!st) begin
      if (m_v) m_cnt++;
      m_pc = nxt;
      m_v  = 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i <= MASK; i++) mem[i] = $urandom;
    reset_n = 1'b0; stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    jump_target = '0; branch_offset = '0;

    //  rst st je jt be off | valid pc cnt addr
    add(1, 0, 0,  0, 0,  0,  0,  0,  0,  0);
    add(1, 0, 0,  0, 0,  0,  1,  0,  0,  1);
    add(1, 0, 0,  0, 0,  0,  1,  1,  1,  2);
    add(1, 0, 0,  0, 0,  0,  1,  2,  2,  3);
    add(1, 0, 1, 40, 0,  0,  1,  3,  3, 40);
    add(1, 0, 0,  0, 0,  0,  1, 40,  4, 41);
    add(1, 0, 1, 10, 0,  0,  1, 41,  5, 10);
    add(1, 0, 0,  0, 1, -5,  1, 10,  6,  6);
    add(1, 0, 1, 10, 0,  0,  1,  6,  7, 10);
    add(1, 0, 1, 20, 1, -5,  1, 10,  8, 20);
    add(1, 0, 1,  5, 0,  0,  1, 20,  9,  5);
    add(1, 1, 0,  0, 0,  0,  1,  5, 10,  5);
    add(1, 1, 0,  0, 0,  0,  1,  5, 10,  5);
    add(1, 1, 0,  0, 0,  0,  1,  5, 10,  5);
    add(1, 0, 0,  0, 0,  0,  1,  5, 10,  6);
    add(1, 1, 1, 30, 0,  0,  1,  6, 11,  6);
    add(1, 0, 1, 30, 0,  0,  1,  6, 11, 30);
    add(1, 0, 1, 63, 0,  0,  1, 30, 12, 63);
    add(1, 0, 0,  0, 0,  0,  1, 63, 13,  0);
    add(1, 0, 0,  0, 0,  0,  1,  0, 14,  1);
    add(1, 0, 0,  0, 1, -3,  1,  1, 15, 63);
    add(1, 0, 0,  0, 1,  2,  1, 63, 16,  2);
    add(1, 0, 1,  9, 0,  0,  1,  2, 17,  9);
    add(0, 1, 1, 20, 0,  0,  1,  9, 18,  0);
    add(1, 0, 1, 33, 0,  0,  0,  0,  0,  0);
    add(1, 0, 0,  0, 0,  0,  1,  0,  0,  1);
    add(0, 0, 0,  0, 0,  0,  1,  1,  1,  0);
    add(1, 1, 0,  0, 1,  7,  0,  0,  0,  0);
    add(1, 0, 0,  0, 0,  0,  0,  0,  0,  0);
    add(1, 0, 0,  0, 0,  0,  1,  0,  0,  1);

    @(negedge clock);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 1, 1, 5, 1, 3, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i])
      run_cycle(tbl[i].rst_n, tbl[i].st, tbl[i].je, tbl[i].jt, tbl[i].be, tbl[i].off,
                1, tbl[i].ev, tbl[i].epc, tbl[i].ecnt, tbl[i].eaddr, 1);

    for (int k = 0; k < 400; k++) begin
      bit rn, st, je, be;
      int jt, off;
      rn  = ($urandom_range(0, 49) != 0);
      st  = ($urandom_range(0, 3) == 0);
      je  = ($urandom_range(0, 6) == 0);
      be  = ($urandom_range(0, 4) == 0);
      jt  = int'($urandom);
      off = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 16)) - 8;
      run_cycle(rn, st, je, jt, be, off, 0, 0, 0, 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the control decoder. It owns the PC, drives the synchronous instruction memory, and presents the fetched instruction plus its split fields (opcode, rd, rs, rt, shamt, ALUop, immediate, target) to control and datapath. It accepts jump/branch redirects back from the decode stage with zero bubbles, and a stall that freezes the presented instruction.

Parameters:
ADDR_W, 12, instruction-memory word-address width; PC wraps modulo 2^ADDR_W.
RESET_PC, 0, word address fetched first after reset.

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
stall  input  1  hold the current instruction and PC
jump_en  input  1  redirect to the jump target; qualified internally by instr_valid
jump_target  input  27  absolute word target; low ADDR_W bits used
branch_en  input  1  redirect to PC+1+sext(branch_offset); qualified by instr_valid
branch_offset  input  17  signed word offset
imem_addr  output  ADDR_W  combinational address to the synchronous IMEM (data returns next cycle)
imem_q  input  32  IMEM read data for the previous cycle's imem_addr
instr_valid  output  1  instr and fields are a real instruction
instr  output  32  imem_q when valid, else 32'h0
pc_out  output  32  zero-extended word address of instr
pc_plus1  output  32  zero-extended (pc_out+1) mod 2^ADDR_W, used for jal link
opcode  output  5  instr[31:27]
rd  output  5  instr[26:22]
rs  output  5  instr[21:17]
rt  output  5  instr[16:12]
shamt  output  5  instr[11:7]
alu_op  output  5  instr[6:2]
imm_sext  output  32  sign-extended instr[16:0]
target  output  27  instr[26:0]
fetch_count  output  32  number of instructions handed off (valid and not stalled)

Behaviour:
- State: pc_f (next fetch address), pc_d (address of instruction in imem_q), valid_d, fetch_count.
- Reset (reset_n=0 at an edge): pc_f<=RESET_PC, pc_d<=RESET_PC, valid_d<=0, fetch_count<=0.
- While reset_n=0 and in the first cycle after release: instr_valid=0, instr=0, all fields 0, imem_addr=pc_f.
- redirect = instr_valid & (jump_en | branch_en).
- tgt = jump_en ? jump_target[ADDR_W-1:0] : (pc_d+1+sext(branch_offset)) mod 2^ADDR_W. Jump has priority over branch.
- imem_addr (combinational, priority order):
  - stall: pc_d (re-fetch the held instruction so imem_q stays stable).
  - else redirect: tgt.
  - else: pc_f.
- Edge update when not in reset:
  - stall=1: pc_f, pc_d, valid_d and fetch_count hold.
  - stall=0: pc_d<=imem_addr, pc_f<=imem_addr+1 (mod), valid_d<=1. fetch_count increments if instr_valid.
- Redirect bubble: none. The wrong-path word at the old pc_f is never fetched, so the target instruction is valid the next cycle.
- Stall together with redirect: stall wins. The same instruction stays presented, so the redirect is reapplied when the stall drops.
- Stall during the invalid post-reset cycle: valid_d stays 0 until the first unstalled edge.
- jump_en/branch_en while instr_valid=0: ignored.
- First valid instruction: mem[RESET_PC], 2 cycles after reset_n rises.
- Increment latency: 1 instruction per unstalled cycle.
- PC wrap: after address 2^ADDR_W-1 comes address 0. Branch arithmetic wraps identically.
- Wrap, both directions: the branch offset may be negative.
- fetch_count wraps modulo 2^32.
- Output zeroing: all field outputs derive from instr, so they are 0 when invalid. This is a harmless R-type add into $0.
- Reset asserted mid-stall or mid-redirect: reset dominates. The next cycle is invalid and fetch restarts at RESET_PC.

Test Plan:
- Reset then run, IMEM word n = n: cycle 1 after release instr_valid=0; then instr = 0,1,2,3 on consecutive cycles with pc_out = 0,1,2,3; pc_plus1 = pc_out+1.
- Jump: at pc_out=3 assert jump_en with jump_target=40 -> next cycle pc_out=40, instr=mem[40], no invalid cycle; fetch_count +1 per valid cycle.
- Branch: at pc_out=10 with branch_offset=-5 -> next pc_out=6. Same test with jump_en also high and jump_target=20 -> pc_out=20.
- Stall for 3 cycles at pc_out=5: pc_out=5, instr=mem[5], imem_addr=5 throughout, fetch_count frozen. On release -> pc_out=6. Stall plus jump_en -> jump taken on the first unstalled cycle.
- Wrap, ADDR_W=4: pc_out 15 -> 0. At pc_out=1 with branch_offset=-3 -> pc_out=15.
- Reset pulled low mid-run at pc_out=9 -> next cycle instr_valid=0, fetch_count=0, then restart from pc_out=0. A redirect while instr_valid=0 is ignored.
